trap_return_unit: RTL and testbench



---
 rtl/trap_return_unit_pkg.sv | 34 +++
 rtl/trap_return_unit_csr.sv | 91 +++++++++
 rtl/trap_return_unit.sv | 136 +++++++++++++
 tb/tb_trap_return_unit.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/trap_return_unit_pkg.sv
// Shared constants, CSR addresses and FSM encoding for the trap/return unit.
package trap_return_unit_pkg;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;

    localparam logic [1:0] PRIV_U = 2'b00;
    localparam logic [1:0] PRIV_S = 2'b01;
    localparam logic [1:0] PRIV_M = 2'b11;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    localparam logic [3:0] ECALL_U = 4'd8;
    localparam logic [3:0] ECALL_S = 4'd9;
    localparam logic [3:0] ECALL_M = 4'd11;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FLUSH    = 2'd1,
        REDIRECT = 2'd2
    } trapState_t;

    // The reserved privilege encoding 2 is never stored; it collapses to U.
    function automatic logic [1:0] legalizeMpp(input logic [1:0] value);
        return (value == 2'b10) ? PRIV_U : value;
    endfunction

endpackage

// File: rtl/trap_return_unit_csr.sv
// Machine trap CSR storage: mstatus fields, mtvec, mepc, mcause, mtval,
// with the read mux and write masking. Trap/return updates come from the top.
module trap_csr_file
    import trap_return_unit_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] MTVEC_RESET = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [11:0]     csrAddr,
    input  logic            csrWe,
    input  logic [XLEN-1:0] csrWdata,
    output logic [XLEN-1:0] csrRdata,
    input  logic            trapCommit,
    input  logic [3:0]      trapCause,
    input  logic [XLEN-1:0] trapPC,
    input  logic [XLEN-1:0] trapVal,
    input  logic [1:0]      nowPriv,
    input  logic            mretCommit,
    output logic [XLEN-1:0] mtvec,
    output logic [XLEN-1:0] mepc,
    output logic [1:0]      mpp
);

    logic            mie;
    logic            mpie;
    logic [3:0]      mcause;
    logic [XLEN-1:0] mtval;

    // mstatus fields: trap entry stacks MIE, mret unstacks it, software writes otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mie  <= 1'b0;
            mpie <= 1'b0;
            mpp  <= PRIV_U;
        end else if (trapCommit) begin
            mpie <= mie;
            mie  <= 1'b0;
            mpp  <= nowPriv;
        end else if (mretCommit) begin
            mie  <= mpie;
            mpie <= 1'b1;
            mpp  <= PRIV_U;
        end else if (csrWe && csrAddr == CSR_MSTATUS) begin
            mie  <= csrWdata[MSTATUS_MIE];
            mpie <= csrWdata[MSTATUS_MPIE];
            mpp  <= legalizeMpp(csrWdata[MSTATUS_MPP_HI:MSTATUS_MPP_LO]);
        end
    end

    // Trap vector and trap-record CSRs; mtvec/mepc stay word aligned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mtvec  <= MTVEC_RESET;
            mepc   <= '0;
            mcause <= '0;
            mtval  <= '0;
        end else if (trapCommit) begin
            mepc   <= {trapPC[XLEN-1:2], 2'b00};
            mcause <= trapCause;
            mtval  <= trapVal;
        end else if (csrWe) begin
            case (csrAddr)
                CSR_MTVEC:  mtvec  <= {csrWdata[XLEN-1:2], 2'b00};
                CSR_MEPC:   mepc   <= {csrWdata[XLEN-1:2], 2'b00};
                CSR_MCAUSE: mcause <= csrWdata[3:0];
                CSR_MTVAL:  mtval  <= csrWdata;
                default:    ;
            endcase
        end
    end

    // Combinational read mux; unmapped addresses and unimplemented bits read zero.
    always_comb begin
        csrRdata = '0;
        case (csrAddr)
            CSR_MSTATUS: begin
                csrRdata[MSTATUS_MIE]                   = mie;
                csrRdata[MSTATUS_MPIE]                  = mpie;
                csrRdata[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = mpp;
            end
            CSR_MTVEC:   csrRdata = mtvec;
            CSR_MEPC:    csrRdata = mepc;
            CSR_MCAUSE:  csrRdata[3:0] = mcause;
            CSR_MTVAL:   csrRdata = mtval;
            default:     csrRdata = '0;
        endcase
    end

endmodule

// File: rtl/trap_return_unit.sv
// Trap entry / mret return sequencer: commits trap CSRs, owns the current
// privilege mode, and runs the flush-then-redirect handshake with the pipeline.
module trap_return_unit
    import trap_return_unit_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] MTVEC_RESET = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_trapValid,
    input  logic [3:0]      i_trapCause,
    input  logic [XLEN-1:0] i_trapPC,
    input  logic [XLEN-1:0] i_trapVal,
    input  logic            i_mretValid,
    input  logic [11:0]     i_csrAddr,
    input  logic            i_csrWe,
    input  logic [XLEN-1:0] i_csrWdata,
    output logic [XLEN-1:0] o_csrRdata,
    input  logic            i_flushAck,
    output logic            o_flushReq,
    output logic            o_redirectValid,
    output logic [XLEN-1:0] o_redirectPC,
    output logic [1:0]      o_nowPrivMode,
    output logic            o_busy
);

    trapState_t      state;
    trapState_t      nextState;
    logic [1:0]      privMode;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] redirectPC;
    logic [XLEN-1:0] mtvec;
    logic [XLEN-1:0] mepc;
    logic [1:0]      mpp;
    logic            trapTake;
    logic            mretTake;
    logic            csrWeGated;

    // Requests are only accepted in IDLE; a trap beats a simultaneous mret,
    // and software CSR writes lose to either.
    assign trapTake   = (state == IDLE) && i_trapValid;
    assign mretTake   = (state == IDLE) && i_mretValid && !i_trapValid;
    assign csrWeGated = (state == IDLE) && i_csrWe && !i_trapValid && !i_mretValid;

    trap_csr_file #(
        .XLEN        (XLEN),
        .MTVEC_RESET (MTVEC_RESET)
    ) csrFile (
        .clk        (clk),
        .rst_n      (rst_n),
        .csrAddr    (i_csrAddr),
        .csrWe      (csrWeGated),
        .csrWdata   (i_csrWdata),
        .csrRdata   (o_csrRdata),
        .trapCommit (trapTake),
        .trapCause  (i_trapCause),
        .trapPC     (i_trapPC),
        .trapVal    (i_trapVal),
        .nowPriv    (privMode),
        .mretCommit (mretTake),
        .mtvec      (mtvec),
        .mepc       (mepc),
        .mpp        (mpp)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state and handshake outputs, decoded from the current state.
    always_comb begin
        nextState       = state;
        o_flushReq      = 1'b0;
        o_redirectValid = 1'b0;
        o_busy          = 1'b0;
        case (state)
            IDLE: begin
                if (trapTake || mretTake) begin
                    nextState = FLUSH;
                end
            end
            FLUSH: begin
                o_flushReq = 1'b1;
                o_busy     = 1'b1;
                if (i_flushAck) begin
                    nextState = REDIRECT;
                end
            end
            REDIRECT: begin
                o_redirectValid = 1'b1;
                o_busy          = 1'b1;
                nextState       = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    // Current privilege: trap entry raises to M, mret drops to the stacked MPP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            privMode <= PRIV_M;
        end else if (trapTake) begin
            privMode <= PRIV_M;
        end else if (mretTake) begin
            privMode <= mpp;
        end
    end

    // Target is captured at commit (so a later mtvec/mepc change cannot leak in),
    // and copied to the visible redirect PC only as REDIRECT begins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            target     <= '0;
            redirectPC <= '0;
        end else begin
            if (trapTake) begin
                target <= mtvec;
            end else if (mretTake) begin
                target <= mepc;
            end
            if (state == FLUSH && i_flushAck) begin
                redirectPC <= target;
            end
        end
    end

    assign o_redirectPC  = redirectPC;
    assign o_nowPrivMode = privMode;

endmodule

// File: tb/tb_trap_return_unit.sv
// Randomized self-checking bench for trap_return_unit against a transaction-level model.
module tb_trap_return_unit;
    import trap_return_unit_pkg::*;

    localparam int          XLEN           = 32;
    localparam logic [31:0] TB_MTVEC_RESET = 32'h0000_0040;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_trapValid, i_mretValid, i_csrWe, i_flushAck;
    logic [3:0]  i_trapCause;
    logic [31:0] i_trapPC, i_trapVal, i_csrWdata;
    logic [11:0] i_csrAddr;
    logic [31:0] o_csrRdata, o_redirectPC;
    logic        o_flushReq, o_redirectValid, o_busy;
    logic [1:0]  o_nowPrivMode;

    int checkCount = 0;
    int errorCount = 0;

    // Reference model state, updated per accepted transaction.
    logic        mMie, mMpie;
    logic [1:0]  mMpp, mPriv;
    logic [3:0]  mMcause;
    logic [31:0] mMtvec, mMepc, mMtval, mTarget, mRedirectPC;

    logic [11:0] mappedAddrs [5] = '{CSR_MSTATUS, CSR_MTVEC, CSR_MEPC, CSR_MCAUSE, CSR_MTVAL};

    trap_return_unit #(
        .XLEN        (XLEN),
        .MTVEC_RESET (TB_MTVEC_RESET)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_trapValid     (i_trapValid),
        .i_trapCause     (i_trapCause),
        .i_trapPC        (i_trapPC),
        .i_trapVal       (i_trapVal),
        .i_mretValid     (i_mretValid),
        .i_csrAddr       (i_csrAddr),
        .i_csrWe         (i_csrWe),
        .i_csrWdata      (i_csrWdata),
        .o_csrRdata      (o_csrRdata),
        .i_flushAck      (i_flushAck),
        .o_flushReq      (o_flushReq),
        .o_redirectValid (o_redirectValid),
        .o_redirectPC    (o_redirectPC),
        .o_nowPrivMode   (o_nowPrivMode),
        .o_busy          (o_busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        mMie = 1'b0; mMpie = 1'b0; mMpp = 2'd0; mPriv = 2'd3;
        mMcause = 4'd0; mMtvec = TB_MTVEC_RESET; mMepc = 32'd0; mMtval = 32'd0;
        mTarget = 32'd0; mRedirectPC = 32'd0;
    endtask

    function automatic logic [31:0] modelRead(input logic [11:0] addr);
        case (addr)
            12'h300: return (32'(mMie) << 3) | (32'(mMpie) << 7) | (32'(mMpp) << 11);
            12'h305: return mMtvec;
            12'h341: return mMepc;
            12'h342: return 32'(mMcause);
            12'h343: return mMtval;
            default: return 32'd0;
        endcase
    endfunction

    task automatic modelWrite(input logic [11:0] addr, input logic [31:0] data);
        case (addr)
            12'h300: begin
                mMie  = data[3];
                mMpie = data[7];
                mMpp  = (data[12:11] == 2'd2) ? 2'd0 : data[12:11];
            end
            12'h305: mMtvec  = data & 32'hFFFF_FFFC;
            12'h341: mMepc   = data & 32'hFFFF_FFFC;
            12'h342: mMcause = data[3:0];
            12'h343: mMtval  = data;
            default: ;
        endcase
    endtask

    function automatic logic [3:0] ecallCause(input logic [1:0] priv);
        case (priv)
            2'd0:    return ECALL_U;
            2'd1:    return ECALL_S;
            default: return ECALL_M;
        endcase
    endfunction

    task automatic clearInputs();
        i_trapValid = 1'b0; i_mretValid = 1'b0; i_csrWe = 1'b0; i_flushAck = 1'b0;
        i_trapCause = 4'd0; i_trapPC = 32'd0; i_trapVal = 32'd0;
        i_csrAddr = 12'd0; i_csrWdata = 32'd0;
    endtask

    task automatic csrWrite(input logic [11:0] addr, input logic [31:0] data);
        @(negedge clk);
        i_csrAddr = addr; i_csrWdata = data; i_csrWe = 1'b1;
        @(posedge clk);
        #1 i_csrWe = 1'b0;
        modelWrite(addr, data);
    endtask

    task automatic csrCheck(input string tag, input logic [11:0] addr);
        @(negedge clk);
        i_csrAddr = addr;
        #1 checkOutput(tag, o_csrRdata, modelRead(addr));
    endtask

    task automatic checkAllCsrs();
        csrCheck("mstatus", CSR_MSTATUS);
        csrCheck("mtvec", CSR_MTVEC);
        csrCheck("mepc", CSR_MEPC);
        csrCheck("mcause", CSR_MCAUSE);
        csrCheck("mtval", CSR_MTVAL);
        checkOutput("priv", 32'(o_nowPrivMode), 32'(mPriv));
    endtask

    // One trap and/or mret request, followed by the full flush/redirect handshake.
    task automatic applyStimulus(input bit isTrap, input bit isMret, input logic [3:0] cause,
                                 input logic [31:0] pc, input logic [31:0] val, input int ackDelay,
                                 input bit spurious, input bit conflictWrite);
        int flushCycles;
        @(negedge clk);
        i_trapValid = isTrap; i_mretValid = isMret;
        i_trapCause = cause; i_trapPC = pc; i_trapVal = val;
        if (conflictWrite) begin
            i_csrWe = 1'b1;
            i_csrAddr = mappedAddrs[$urandom_range(0, 4)];
            i_csrWdata = $urandom;
        end
        if (isTrap) begin
            mTarget = mMtvec;
            mMepc = pc & 32'hFFFF_FFFC; mMcause = cause; mMtval = val;
            mMpie = mMie; mMie = 1'b0; mMpp = mPriv; mPriv = 2'd3;
        end else if (isMret) begin
            mTarget = mMepc;
            mMie = mMpie; mMpie = 1'b1; mPriv = mMpp; mMpp = 2'd0;
        end
        @(posedge clk);
        #1 clearInputs();
        flushCycles = 0;
        @(negedge clk);
        checkOutput("busyAfterReq", 32'(o_busy), 32'd1);
        checkOutput("privAfterReq", 32'(o_nowPrivMode), 32'(mPriv));
        while (o_flushReq === 1'b1 && flushCycles < 20) begin
            flushCycles++;
            i_flushAck = (flushCycles > ackDelay);
            if (spurious) begin
                i_trapValid = 1'($urandom_range(0, 1));
                i_mretValid = 1'($urandom_range(0, 1));
                i_trapCause = 4'($urandom);
                i_trapPC = $urandom; i_trapVal = $urandom;
                i_csrWe = 1'b1; i_csrAddr = CSR_MTVAL; i_csrWdata = $urandom;
            end
            @(negedge clk);
        end
        mRedirectPC = mTarget;
        checkOutput("flushCycles", 32'(flushCycles), 32'(ackDelay + 1));
        checkOutput("redirectValid", 32'(o_redirectValid), 32'd1);
        checkOutput("redirectPC", o_redirectPC, mRedirectPC);
        checkOutput("busyRedirect", 32'(o_busy), 32'd1);
        i_flushAck = 1'b0;
        @(negedge clk);
        clearInputs();
        checkOutput("redirectOneShot", 32'(o_redirectValid), 32'd0);
        checkOutput("busyDone", 32'(o_busy), 32'd0);
        checkOutput("redirectPCHold", o_redirectPC, mRedirectPC);
        checkOutput("flushDone", 32'(o_flushReq), 32'd0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int op;
        clearInputs();
        modelReset();
        repeat (2) @(negedge clk);
        checkOutput("rstFlushReq", 32'(o_flushReq), 32'd0);
        checkOutput("rstRedirectValid", 32'(o_redirectValid), 32'd0);
        checkOutput("rstRedirectPC", o_redirectPC, 32'd0);
        checkOutput("rstBusy", 32'(o_busy), 32'd0);
        checkOutput("rstPriv", 32'(o_nowPrivMode), 32'd3);
        rst_n = 1'b1;
        checkAllCsrs();

        // mtvec alignment, and MPP=2 collapsing to U while setting MIE/MPIE.
        csrWrite(CSR_MTVEC, 32'h0000_0103);
        csrCheck("mtvecAligned", CSR_MTVEC);
        checkOutput("mtvecConst", o_csrRdata, 32'h0000_0100);
        csrWrite(CSR_MSTATUS, 32'h0000_1088);
        csrCheck("mstatusMpp2", CSR_MSTATUS);
        checkOutput("mstatusConst", o_csrRdata, 32'h0000_0088);

        // Drop to U via mret, then an ecall trap with a 3-cycle flush.
        applyStimulus(1'b0, 1'b1, 4'd0, 32'd0, 32'd0, 0, 1'b0, 1'b0);
        checkOutput("privUser", 32'(o_nowPrivMode), 32'd0);
        applyStimulus(1'b1, 1'b0, ECALL_U, 32'h0000_0206, 32'h12, 2, 1'b0, 1'b0);
        checkOutput("trapTarget", o_redirectPC, 32'h0000_0100);
        checkAllCsrs();
        csrCheck("mepcConst", CSR_MEPC);
        checkOutput("mepcValue", o_csrRdata, 32'h0000_0204);

        // mret with ack tied high: redirect lands two cycles after the request.
        applyStimulus(1'b0, 1'b1, 4'd0, 32'd0, 32'd0, 0, 1'b0, 1'b0);
        checkOutput("mretTarget", o_redirectPC, 32'h0000_0204);
        checkAllCsrs();

        // Trap+mret together with a conflicting CSR write and spurious requests while busy.
        applyStimulus(1'b1, 1'b1, 4'd2, 32'h0000_1234, 32'hDEAD_BEEF, 2, 1'b1, 1'b1);
        checkAllCsrs();

        // Randomized mix of CSR traffic, traps and returns.
        for (int i = 0; i < 60; i++) begin
            op = $urandom_range(0, 4);
            case (op)
                0: csrWrite((($urandom_range(0, 3) == 0) ? 12'($urandom) : mappedAddrs[$urandom_range(0, 4)]), $urandom);
                1: csrCheck("randRead", (($urandom_range(0, 2) == 0) ? 12'($urandom) : mappedAddrs[$urandom_range(0, 4)]));
                2: applyStimulus(1'b1, 1'b0, (($urandom_range(0, 1) == 1) ? ecallCause(mPriv) : 4'($urandom)),
                                 $urandom, $urandom, $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                3: applyStimulus(1'b0, 1'b1, 4'd0, 32'd0, 32'd0, $urandom_range(0, 3),
                                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                default: applyStimulus(1'b1, 1'b1, 4'($urandom), $urandom, $urandom, $urandom_range(0, 3),
                                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            endcase
            if (op >= 2) begin
                checkAllCsrs();
            end
        end

        // Asynchronous reset while FLUSH is pending.
        csrWrite(CSR_MTVAL, 32'hCAFE_0001);
        @(negedge clk);
        i_trapValid = 1'b1; i_trapCause = ECALL_M; i_trapPC = 32'h0000_0800; i_trapVal = 32'h5;
        @(posedge clk);
        #1 clearInputs();
        @(negedge clk);
        checkOutput("flushBeforeReset", 32'(o_flushReq), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        modelReset();
        checkOutput("resetFlushDrop", 32'(o_flushReq), 32'd0);
        checkOutput("resetBusy", 32'(o_busy), 32'd0);
        checkOutput("resetPriv", 32'(o_nowPrivMode), 32'd3);
        checkOutput("resetRedirectPC", o_redirectPC, 32'd0);
        i_flushAck = 1'b1;
        repeat (2) begin
            @(negedge clk);
            checkOutput("noRedirectInReset", 32'(o_redirectValid), 32'd0);
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checkOutput("noRedirectAfterReset", 32'(o_redirectValid), 32'd0);
        end
        i_flushAck = 1'b0;
        checkAllCsrs();

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
